// File: rtl/dr_elastic_buffer.sv
// Elastic buffer between USB2 word recovery and the decoder: pre-fill, FWFT drain, sticky over/underflow.
// Optional watermark outputs are enabled by defining DR_WATERMARK_EN.
module dr_elastic_buffer #(
    parameter int unsigned WIDTH        = 1,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned START_LEVEL  = 8
`ifdef DR_WATERMARK_EN
    ,
    parameter int unsigned ALMOST_FULL  = DEPTH - 2,
    parameter int unsigned ALMOST_EMPTY = 2
`endif
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    input  logic                     flush,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     running,
    output logic                     overflow,
    output logic                     underflow
`ifdef DR_WATERMARK_EN
    ,
    output logic                     almost_full,
    output logic                     almost_empty
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] START_LVL = (AW+1)'(START_LEVEL);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_ERR} state_t;

    state_t           r_state;
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_overflow;
    logic             r_underflow;

    logic [AW:0]      w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_out_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf;
    logic             w_udf;

    always_comb begin
        w_level     = r_wptr - r_rptr;
        w_empty     = (r_wptr == r_rptr);
        w_full      = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
        w_out_valid = (r_state == ST_RUN) && !w_empty;
        w_pop       = w_out_valid && out_ready;
        // A full buffer still accepts a word when the same cycle frees a slot.
        w_push      = in_valid && (r_state != ST_ERR) && (!w_full || w_pop);
        w_ovf       = in_valid && (r_state != ST_ERR) && w_full && !w_pop;
        w_udf       = (r_state == ST_RUN) && out_ready && w_empty;
    end

    always_ff @(posedge clock) begin
        if (w_push && !flush) begin
            r_mem[r_wptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_FILL;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_FILL;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_udf) begin
                r_underflow <= 1'b1;
            end
            case (r_state)
                ST_FILL: begin
                    if (w_ovf) begin
                        r_state <= ST_ERR;
                    end else if (w_level >= START_LVL) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_ovf || w_udf) begin
                        r_state <= ST_ERR;
                    end
                end
                default: r_state <= ST_ERR;
            endcase
        end
    end

    // Data is forced to zero while not valid so reset leaves a clean output.
    assign out_data  = w_out_valid ? r_mem[r_rptr[AW-1:0]] : '0;
    assign out_valid = w_out_valid;
    assign level     = w_level;
    assign running   = (r_state == ST_RUN);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifdef DR_WATERMARK_EN
    assign almost_full  = (w_level >= (AW+1)'(ALMOST_FULL));
    assign almost_empty = (w_level <= (AW+1)'(ALMOST_EMPTY));
`endif

endmodule

// File: tb/tb_dr_elastic_buffer.sv
// Directed bench for dr_elastic_buffer: table of vectors plus hand sequences for streaming and async reset.
module tb_dr_elastic_buffer;

    logic       clk;
    int         n_tests;
    int         n_fail;

    // Instance A: WIDTH=8, DEPTH=16, START_LEVEL=8
    logic       a_rst;
    logic [7:0] a_in_data;
    logic       a_in_valid;
    logic       a_flush;
    logic [7:0] a_out_data;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [4:0] a_level;
    logic       a_running;
    logic       a_overflow;
    logic       a_underflow;

    // Instance C: WIDTH=8, DEPTH=4, START_LEVEL=1
    logic       c_rst;
    logic [7:0] c_in_data;
    logic       c_in_valid;
    logic       c_flush;
    logic [7:0] c_out_data;
    logic       c_out_valid;
    logic       c_out_ready;
    logic [2:0] c_level;
    logic       c_running;
    logic       c_overflow;
    logic       c_underflow;

    dr_elastic_buffer #(.WIDTH(8), .DEPTH(16), .START_LEVEL(8)) u_a (
        .clock(clk), .reset(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .flush(a_flush), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .level(a_level), .running(a_running),
        .overflow(a_overflow), .underflow(a_underflow)
    );

    dr_elastic_buffer #(.WIDTH(8), .DEPTH(4), .START_LEVEL(1)) u_c (
        .clock(clk), .reset(c_rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .flush(c_flush), .out_data(c_out_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .level(c_level), .running(c_running),
        .overflow(c_overflow), .underflow(c_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       rdy;
        logic       fl;
        logic       e_ov;
        logic [7:0] e_od;
        logic [4:0] e_lvl;
        logic       e_run;
        logic       e_ovf;
        logic       e_udf;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] q[$];

    function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic rdy, input logic fl,
                                input logic e_ov, input logic [7:0] e_od, input logic [4:0] e_lvl,
                                input logic e_run, input logic e_ovf, input logic e_udf);
        vec_t v;
        v.iv = iv; v.d = d; v.rdy = rdy; v.fl = fl;
        v.e_ov = e_ov; v.e_od = e_od; v.e_lvl = e_lvl;
        v.e_run = e_run; v.e_ovf = e_ovf; v.e_udf = e_udf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic a_drive(input logic iv, input logic [7:0] d, input logic rdy, input logic fl);
        a_in_valid = iv; a_in_data = d; a_out_ready = rdy; a_flush = fl;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vt.size(); i++) begin
            a_drive(vt[i].iv, vt[i].d, vt[i].rdy, vt[i].fl);
            @(posedge clk); #1;
            chk($sformatf("%s[%0d].out_valid", tag, i), 32'(a_out_valid), 32'(vt[i].e_ov));
            if (vt[i].e_ov)
                chk($sformatf("%s[%0d].out_data", tag, i), 32'(a_out_data), 32'(vt[i].e_od));
            chk($sformatf("%s[%0d].level", tag, i), 32'(a_level), 32'(vt[i].e_lvl));
            chk($sformatf("%s[%0d].running", tag, i), 32'(a_running), 32'(vt[i].e_run));
            chk($sformatf("%s[%0d].overflow", tag, i), 32'(a_overflow), 32'(vt[i].e_ovf));
            chk($sformatf("%s[%0d].underflow", tag, i), 32'(a_underflow), 32'(vt[i].e_udf));
        end
    endtask

    task automatic c_step(input string nm, input logic iv, input logic [7:0] d, input logic rdy,
                          input logic e_ov, input logic [7:0] e_od, input logic [2:0] e_lvl, input logic e_run);
        c_in_valid = iv; c_in_data = d; c_out_ready = rdy; c_flush = 1'b0;
        @(posedge clk); #1;
        chk({nm, ".out_valid"}, 32'(c_out_valid), 32'(e_ov));
        if (e_ov)
            chk({nm, ".out_data"}, 32'(c_out_data), 32'(e_od));
        chk({nm, ".level"}, 32'(c_level), 32'(e_lvl));
        chk({nm, ".running"}, 32'(c_running), 32'(e_run));
        chk({nm, ".flags"}, 32'({c_overflow, c_underflow}), 32'(0));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        a_rst = 1'b0; c_rst = 1'b0;
        a_drive(1'b0, 8'h00, 1'b0, 1'b0);
        c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0; c_flush = 1'b0;

        @(posedge clk); #2;
        chk("reset.level", 32'(a_level), 32'(0));
        chk("reset.out_valid", 32'(a_out_valid), 32'(0));
        chk("reset.out_data", 32'(a_out_data), 32'(0));
        chk("reset.running", 32'(a_running), 32'(0));
        chk("reset.flags", 32'({a_overflow, a_underflow}), 32'(0));
        a_rst = 1'b1;
        @(posedge clk); #1;

        // Pre-fill, drain to empty, underflow, then flush-in-ERR with a discarded push.
        for (int k = 0; k < 8; k++)
            vt.push_back(mk(1'b1, 8'(k), 1'b1, 1'b0, 1'b0, 8'h00, 5'(k + 1), 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 5'd8, 1'b1, 1'b0, 1'b0));
        for (int j = 1; j < 8; j++)
            vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(j), 5'(8 - j), 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0));
        run_table("prefill");

        // Streaming: fill 8, one idle cycle to enter RUN, then 48 cycles of push+pop.
        for (int i = 0; i < 8; i++) begin
            a_drive(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0);
            q.push_back(8'(i * 7 + 3));
            @(posedge clk); #1;
        end
        a_drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("stream.enter_run", 32'({a_running, a_out_valid}), 32'(3));
        chk("stream.first", 32'(a_out_data), 32'(q[0]));
        for (int i = 8; i < 56; i++) begin
            a_drive(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0);
            @(posedge clk); #1;
            q.push_back(8'(i * 7 + 3));
            void'(q.pop_front());
            chk($sformatf("stream[%0d].out_data", i), 32'(a_out_data), 32'(q[0]));
            chk($sformatf("stream[%0d].level", i), 32'(a_level), 32'(8));
        end
        chk("stream.flags", 32'({a_overflow, a_underflow, a_out_valid}), 32'(1));
        a_drive(1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("stream.flush_level", 32'(a_level), 32'(0));
        q.delete();

        // Fill to full with no consumer, full push+pop, overflow, ready ignored in ERR.
        vt.delete();
        for (int i = 0; i < 16; i++)
            vt.push_back(mk(1'b1, 8'(16 + i), 1'b0, 1'b0, (i >= 8), (i >= 8) ? 8'h10 : 8'h00,
                            5'(i + 1), (i >= 8), 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 8'h11, 5'd16, 1'b1, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 8'h00, 5'd16, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 5'd16, 1'b0, 1'b1, 1'b0));
        run_table("overflow");

        // Async reset between edges while in ERR clears immediately.
        a_drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2 a_rst = 1'b0;
        #1;
        chk("areset.level", 32'(a_level), 32'(0));
        chk("areset.overflow", 32'(a_overflow), 32'(0));
        #1 a_rst = 1'b1;
        a_drive(1'b1, 8'h5C, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("areset.resume_level", 32'(a_level), 32'(1));
        chk("areset.resume_state", 32'({a_running, a_out_valid}), 32'(0));
        a_drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Small instance: START_LEVEL=1 latency and async reset while running.
        chk("c.reset", 32'({c_out_valid, c_running, c_level, c_out_data}), 32'(0));
        c_rst = 1'b1;
        @(posedge clk); #1;
        c_step("c0", 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0);
        c_step("c1", 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b1);
        c_step("c2", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1);
        c_step("c3", 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 3'd1, 1'b1);
        c_step("c4", 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 3'd1, 1'b1);
        c_in_valid = 1'b0; c_out_ready = 1'b0;
        #2 c_rst = 1'b0;
        #1;
        chk("c.areset", 32'({c_out_valid, c_running, c_level, c_out_data}), 32'(0));
        #1 c_rst = 1'b1;
        c_step("c5", 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0);
        c_step("c6", 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 3'd1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dr_elastic_buffer.md
Name: dr_elastic_buffer

Overview:
Parametrised elastic buffer for the USB2 data-recovery path. It sits between the bit/word recovery front end and the downstream decoder. Recovered words are pushed with a valid strobe. The consumer drains them with a ready handshake after a programmable pre-fill, which absorbs jitter and rate mismatch. Overflow and underflow are detected, and the buffer locks into an error state until flushed.

Parameters:
WIDTH, 1, data word width in bits (≥1)
DEPTH, 16, storage entries; power of two, ≥4
START_LEVEL, 8, fill level at which draining begins; 1..DEPTH
AW, $clog2(DEPTH), pointer width (derived, localparam)

Ports:
clock  in  1  single system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
in_data  in  WIDTH  recovered word
in_valid  in  1  push request
flush  in  1  synchronous clear (end of packet / resync)
out_data  out  WIDTH  word at read pointer (first-word fall-through)
out_valid  out  1  out_data valid
out_ready  in  1  consumer takes word this cycle
level  out  AW+1  current occupancy, 0..DEPTH
running  out  1  high in RUN state
overflow  out  1  sticky; set by push when full
underflow  out  1  sticky; set by ready when empty in RUN

Behaviour:
- Reset (reset=0, async): pointers=0, level=0, state FILL, out_valid=0, running=0, overflow=0, underflow=0, out_data=0.
- Storage: DEPTH×WIDTH array; wptr/rptr are AW+1 bits wide, with an extra wrap bit. empty = (wptr==rptr). full = (ptr[AW-1:0] equal and wrap bits differ). level = wptr−rptr, modulo 2^(AW+1).
- pop = out_valid & out_ready.
- push = in_valid & state≠ERR & (!full | pop). A push when full is legal only with a same-cycle pop.
- States:
  - FILL: out_valid=0; pushes accepted. Move to RUN at the clock edge where registered level ≥ START_LEVEL, so out_valid rises one cycle after the threshold is reached.
  - RUN: running=1; out_valid = !empty; out_data = mem[rptr]. Reaching the threshold therefore never produces an empty RUN entry cycle.
  - ERR: out_valid=0, running=0, pushes and pops ignored; flags hold.
- Error transitions:
  - in_valid & full & !pop (FILL or RUN): overflow←1, word dropped, state→ERR.
  - RUN & out_ready & empty: underflow←1, state→ERR.
  - If both conditions occur in the same cycle, both flags are set.
- flush=1 (any state): next cycle pointers=0, level=0, state FILL, flags cleared. Flush has priority over a same-cycle push, pop or error; that cycle's in_data is discarded.
- Latency: a word pushed at edge N is visible on out_data after edge N when in RUN and the buffer was empty.
- Simultaneous push and pop: level unchanged, both pointers advance. Pointers wrap modulo DEPTH with the wrap bit toggling.
- out_ready in FILL or ERR is ignored, with no underflow.
- Reset asserted mid-packet: immediate clear; buffer contents are don't-care.

Optional Feature:
DR_WATERMARK_EN
- Defined: adds parameters ALMOST_FULL (default DEPTH−2) and ALMOST_EMPTY (default 2), and outputs almost_full = (level ≥ ALMOST_FULL) and almost_empty = (level ≤ ALMOST_EMPTY). Both outputs are combinational from the registered level, and both read 0/1 respectively at reset.
- Undefined: these ports and parameters do not exist; all other behaviour is identical.

Test Plan:
1. Pre-fill: defaults, push 0x0..0x7 on 8 consecutive cycles with out_ready=1 → out_valid=0 until one cycle after level=8; then out_data=0,1,..,7 in order; running=1.
2. Streaming: continuous push and pop of alternating 0/1 (WIDTH=1) for 3×DEPTH cycles → level constant at 8, pointers wrap, no flags set, output sequence matches input.
3. Overflow: out_ready=0, push 17 words → level=16 after 16 pushes; 17th sets overflow=1, state ERR, out_valid=0, level stays 16.
4. Underflow: reach RUN, stop pushes, hold out_ready=1 → 8 words drained, then the next cycle sets underflow=1, out_valid=0, running=0.
5. Flush priority: in ERR, assert flush with in_valid=1 → next cycle level=0, flags=0, state FILL, pushed word not stored.
6. Async reset mid-stream: drop reset between clock edges → outputs clear immediately, not at the next edge. Resume with WIDTH=8, DEPTH=4, START_LEVEL=1: first word appears one cycle after push.
